// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side blocks.
package uart_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_WAIT} arb_state_e;

  localparam int UART_DATA_W      = 8;
  localparam int UART_ARB_TIMEOUT = 4096;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and transmitter-side handshake bundle of the UART TX arbiter.
interface uart_tx_arb_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      tx_send_req;
  logic [DATA_W-1:0]         tx_din;
  logic                      tx_send_ack;
  logic                      tx_done;

  modport master (
    input  req, req_data, tx_send_ack, tx_done,
    output req_ack, tx_send_req, tx_din
  );

  modport slave (
    output req, req_data, tx_send_ack, tx_done,
    input  req_ack, tx_send_req, tx_din
  );
endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: first set req bit after last_grant, wrapping.
module uart_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Scan farthest-to-nearest so the nearest hit after last_grant wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional watchdog abort enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int TIMEOUT_CYC = UART_ARB_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arb_if.master              bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e        state, state_d;
  logic [IDX_W-1:0]  last_grant;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic              grant_ld;
  logic              ack_fire;
  logic              abort;
  logic [NUM_REQ-1:0] req_ack_r;
  logic [DATA_W-1:0] tx_din_r;
  logic [DATA_W-1:0] req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expired;
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    grant_ld = 1'b0;
    ack_fire = 1'b0;
    abort    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (gnt_valid) begin
          grant_ld = 1'b1;
          state_d  = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (bus.tx_send_ack) begin
          ack_fire = 1'b1;
          state_d  = ARB_WAIT;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          abort   = 1'b1;
          state_d = ARB_IDLE;
        end
`endif
      end
      ARB_WAIT: begin
        if (bus.tx_done) begin
          state_d = ARB_IDLE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          abort   = 1'b1;
          state_d = ARB_IDLE;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant capture, acknowledge pulse and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_din_r   <= '0;
      grant_id   <= '0;
      req_ack_r  <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      req_ack_r <= '0;
      if (grant_ld) begin
        tx_din_r <= req_byte[gnt_idx];
        grant_id <= gnt_idx;
      end
      if (ack_fire) begin
        req_ack_r[grant_id] <= 1'b1;
        last_grant          <= grant_id;
      end
      if (abort) begin
        last_grant <= grant_id;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
      if (state_d != state)      wd_cnt <= '0;
      else if (state != ARB_IDLE) wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_err        = 1'b0;
`endif

  assign bus.tx_send_req = (state == ARB_SEND);
  assign bus.tx_din      = tx_din_r;
  assign bus.req_ack     = req_ack_r;
  assign busy            = (state != ARB_IDLE);
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one UART transmitter among NUM_REQ byte-producing requesters using round-robin arbitration.
- Sequences the transmitter handshake: presents the byte with tx_send_req and holds it until tx_send_ack, then waits for tx_done before the next grant.
- Sits between the requester clients and the uart_transmitter in the UART subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width passed to transmitter din.
- TIMEOUT_CYC, 4096, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester send request; level, held until req_ack.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-cycle pulse: the byte of requester i has been accepted by the transmitter.
- tx_send_req  out  1  request to the transmitter to start a frame.
- tx_din  out  DATA_W  byte to the transmitter; stable while tx_send_req=1.
- tx_send_ack  in  1  transmitter has latched tx_din.
- tx_done  in  1  one-cycle pulse: frame (stop bit) finished.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- timeout_err  out  1  one-cycle error pulse; tied to 0 without the optional feature.

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE.
  - The round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any req bit is high in cycle N, the winner is the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
  - The winner's byte is registered into tx_din, grant_id is set, and state becomes SEND.
  - tx_send_req=1 and busy=1 from cycle N+1.
  - No req set: stay in IDLE with all outputs held.
- SEND:
  - tx_send_req and tx_din are held constant until tx_send_ack=1 is sampled in cycle M.
  - In cycle M+1: tx_send_req=0, req_ack[grant_id]=1 for one cycle, last_grant=grant_id, state = WAIT.
  - tx_done is ignored in SEND.
- WAIT:
  - On tx_done=1 in cycle K, state = IDLE in cycle K+1 and busy=0.
  - The earliest next grant is cycle K+1 (tx_send_req in K+2).
  - tx_send_ack is ignored in WAIT and IDLE.
- Requester rules:
  - The byte is captured at grant; later changes to req_data or req are ignored for that transfer.
  - A requester drops req the cycle after its req_ack; a still-high req after that is treated as a new byte.
- Simultaneous requests: exactly one winner per grant. With all requesters asserted continuously, the grant order is 0,1,2,3,0,...
- Reset mid-operation (SEND or WAIT):
  - Return to IDLE the next cycle, outputs cleared, pointer reset; no req_ack issued.
  - The transmitter is reset by the same rst.
- grant_id holds its value after a transfer until the next grant.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to SEND or WAIT and increments each cycle spent there.
  - If it reaches TIMEOUT_CYC-1 without tx_send_ack (in SEND) or tx_done (in WAIT), the next cycle: state = IDLE, tx_send_req=0, timeout_err=1 for one cycle.
  - last_grant = grant_id, so a stuck requester loses priority.
  - No req_ack is issued for a transfer aborted in SEND.
- Disabled: no counter is built, timeout_err is constant 0, and the arbiter waits indefinitely.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_WAIT} arb_state_e;
  - localparam defaults UART_DATA_W=8 and UART_ARB_TIMEOUT=4096.
- Sub-module uart_rr_arb: combinational round-robin picker.
  - Inputs: req, last_grant.
  - Outputs: gnt_valid, gnt_idx.
  - Instantiated once; the FSM, data mux/register and watchdog stay in uart_tx_arb.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5; tx_send_ack 3 cycles after tx_send_req.
  - Expect tx_din=8'hA5 stable throughout SEND.
  - Expect req_ack=4'b0001 for one cycle after the ack, then busy=1 until 1 cycle after tx_done.
- Contention: req=4'b1010 from reset.
  - Expect grant_id=1 first, then 3.
  - Requester 3 is not acked before requester 1's tx_done.
- Fairness: all four req held high, with data 8'h10/11/12/13.
  - Expect tx_din order 10,11,12,13,10 and one req_ack per frame.
- Data capture: after grant, change requester 2's byte from 8'h3C to 8'hFF and drop req.
  - Expect tx_din=8'h3C, the frame is still sent, and req_ack[2] still pulses.
- Reset mid-WAIT: assert rst for 1 cycle.
  - Next cycle: busy=0, tx_send_req=0, no req_ack.
  - With req=4'b1000, grant_id=3 on the next grant.
- Timeout (macro on, TIMEOUT_CYC=16): tx_send_ack never arrives.
  - Expect timeout_err pulse at cycle 16 of SEND, no req_ack, and return to IDLE.
  - Re-arbitration skips to the next requester.
